// File: rtl/alu_acc_stage.sv
// alu_acc_stage: downstream stage of the ALU. add/mul results pass through;
// mad results are summed into a signed accumulator and the chain total is
// emitted on the last beat. Results leave through a 2-entry FIFO.
module alu_acc_stage #(
  parameter int OUT_W = 64,
  parameter int OP_W  = 3,
  parameter int TAG_W = 4,
  parameter logic [OP_W-1:0] OP_ADD = 3'b000,
  parameter logic [OP_W-1:0] OP_MUL = 3'b001,
  parameter logic [OP_W-1:0] OP_MAD = 3'b010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [OUT_W-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_last,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic             busy,
  output logic [7:0]       drop_cnt
);

  localparam int MSB = OUT_W - 1;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             ovf;
  } ent_t;

  state_t           state, state_nxt;
  logic [OUT_W-1:0] acc, acc_nxt;
  logic             ovf_sticky, ovf_sticky_nxt;

  ent_t             mem [2];
  logic             rd_ptr, wr_ptr;
  logic [1:0]       count;

  logic             fire, pop, push;
  logic             is_pass, is_mad;
  logic [OUT_W-1:0] acc_base, sum;
  logic             ovf_base, ovf_now;
  ent_t             push_ent;

  // Ready only looks at occupancy, so there is no combinational path from out_ready.
  assign in_ready  = (count < 2'd2);
  assign fire      = in_valid & in_ready;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;

  assign is_pass = (in_op == OP_ADD) || (in_op == OP_MUL);
  assign is_mad  = (in_op == OP_MAD);

  // acc_clr takes effect before a same-cycle mad beat, so the beat sees a zero base.
  assign acc_base = acc_clr ? '0 : acc;
  assign ovf_base = acc_clr ? 1'b0 : ovf_sticky;
  assign sum      = acc_base + in_data;
  assign ovf_now  = (acc_base[MSB] == in_data[MSB]) & (sum[MSB] != acc_base[MSB]);

  assign push = fire & (is_pass | (is_mad & in_last));

  assign out_data = mem[rd_ptr].data;
  assign out_tag  = mem[rd_ptr].tag;
  assign out_ovf  = mem[rd_ptr].ovf;
  assign busy     = (state == ACCUM);

  // Select what enters the FIFO: pass-through result or the finished chain total.
  always_comb begin
    push_ent = '0;
    if (is_mad) begin
      push_ent.data = sum;
      push_ent.tag  = in_tag;
      push_ent.ovf  = ovf_base | ovf_now;
    end else begin
      push_ent.data = in_data;
      push_ent.tag  = in_tag;
      push_ent.ovf  = 1'b0;
    end
  end

  // Chain FSM and accumulator next-state; add/mul/illegal beats leave them alone.
  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc;
    ovf_sticky_nxt = ovf_sticky;
    if (acc_clr) begin
      state_nxt      = IDLE;
      acc_nxt        = '0;
      ovf_sticky_nxt = 1'b0;
    end
    if (fire && is_mad) begin
      if (in_last) begin
        state_nxt      = IDLE;
        acc_nxt        = '0;
        ovf_sticky_nxt = 1'b0;
      end else begin
        state_nxt      = ACCUM;
        acc_nxt        = sum;
        ovf_sticky_nxt = ovf_base | ovf_now;
      end
    end
  end

  // State, accumulator and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      ovf_sticky <= ovf_sticky_nxt;
    end
  end

  // Saturating count of beats consumed with an unknown op code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= 8'd0;
    else if (fire && !is_pass && !is_mad && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end

  // Two-entry FIFO; a push never coincides with a full FIFO because fire needs in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_alu_acc_stage.sv
// Directed bench for alu_acc_stage with hand-computed expectations.
module tb_alu_acc_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [63:0] in_data;
  logic [3:0]  in_tag;
  logic        in_last;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_tag;
  logic        out_ovf;
  logic        busy;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_acc_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .in_tag(in_tag), .in_last(in_last), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_ovf(out_ovf), .busy(busy), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for a single cycle (caller ensures in_ready=1).
  task automatic beat(input logic [2:0] op, input logic [63:0] d, input logic [3:0] t,
                      input logic last);
    in_valid = 1'b1; in_op = op; in_data = d; in_tag = t; in_last = last;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_data = '0; in_tag = '0;
    in_last = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // add pass-through, one-cycle latency
    beat(3'b000, 64'h5, 4'd3, 1'b0);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_data", out_data, 64'h5);
    chk("add_tag", 64'(out_tag), 64'd3);
    chk("add_ovf", 64'(out_ovf), 64'd0);
    chk("add_busy", 64'(busy), 64'd0);

    // mad chain 10, -3, 7 -> 14
    beat(3'b010, 64'd10, 4'd9, 1'b0);
    chk("mad1_valid", 64'(out_valid), 64'd0);
    chk("mad1_busy", 64'(busy), 64'd1);
    beat(3'b010, 64'hFFFF_FFFF_FFFF_FFFD, 4'd9, 1'b0);
    chk("mad2_valid", 64'(out_valid), 64'd0);
    chk("mad2_busy", 64'(busy), 64'd1);
    beat(3'b010, 64'd7, 4'd9, 1'b1);
    chk("mad3_valid", 64'(out_valid), 64'd1);
    chk("mad3_data", out_data, 64'd14);
    chk("mad3_tag", 64'(out_tag), 64'd9);
    chk("mad3_ovf", 64'(out_ovf), 64'd0);
    chk("mad3_busy", 64'(busy), 64'd0);

    // signed overflow, then sticky cleared for the next chain
    beat(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 4'd1, 1'b0);
    beat(3'b010, 64'd1, 4'd1, 1'b1);
    chk("ovf_data", out_data, 64'h8000_0000_0000_0000);
    chk("ovf_flag", 64'(out_ovf), 64'd1);
    beat(3'b010, 64'd2, 4'd2, 1'b0);
    beat(3'b010, 64'd2, 4'd2, 1'b1);
    chk("ovf2_data", out_data, 64'd4);
    chk("ovf2_flag", 64'(out_ovf), 64'd0);
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // backpressure: two accepted, third held
    out_ready = 1'b0;
    beat(3'b000, 64'hA, 4'd1, 1'b0);
    beat(3'b001, 64'hB, 4'd2, 1'b0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_op = 3'b000; in_data = 64'hC; in_tag = 4'd3;
    step();
    chk("full_hold_data", out_data, 64'hA);
    chk("full_hold_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    chk("bp_pop1_data", out_data, 64'hB);
    chk("bp_pop1_tag", 64'(out_tag), 64'd2);
    chk("bp_pop1_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_pop2_data", out_data, 64'hC);
    chk("bp_pop2_tag", 64'(out_tag), 64'd3);
    chk("bp_pop2_valid", 64'(out_valid), 64'd1);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // acc_clr alongside a last mad beat
    beat(3'b010, 64'd100, 4'd4, 1'b0);
    acc_clr = 1'b1;
    beat(3'b010, 64'd5, 4'd4, 1'b1);
    acc_clr = 1'b0;
    chk("clr_data", out_data, 64'd5);
    chk("clr_busy", 64'(busy), 64'd0);
    // acc_clr alone aborts a chain
    beat(3'b010, 64'd20, 4'd4, 1'b0);
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    chk("clr_abort_busy", 64'(busy), 64'd0);
    beat(3'b010, 64'd3, 4'd4, 1'b1);
    chk("clr_abort_data", out_data, 64'd3);

    // mul interleaved inside a mad chain
    beat(3'b010, 64'd50, 4'd5, 1'b0);
    beat(3'b001, 64'd8, 4'd6, 1'b0);
    chk("ilv_mul_data", out_data, 64'd8);
    chk("ilv_mul_tag", 64'(out_tag), 64'd6);
    chk("ilv_busy", 64'(busy), 64'd1);
    beat(3'b010, 64'd1, 4'd7, 1'b1);
    chk("ilv_mad_data", out_data, 64'd51);
    chk("ilv_mad_tag", 64'(out_tag), 64'd7);
    step();

    // illegal op codes: dropped, counter saturates
    in_valid = 1'b1; in_op = 3'b111; in_data = 64'hDEAD;
    for (int i = 0; i < 10; i++) step();
    chk("drop_10", 64'(drop_cnt), 64'd10);
    for (int i = 0; i < 290; i++) step();
    in_valid = 1'b0; in_op = 3'b000;
    chk("drop_sat", 64'(drop_cnt), 64'd255);
    chk("drop_no_out", 64'(out_valid), 64'd0);

    // reset mid-chain with a queued entry
    beat(3'b010, 64'd9, 4'd8, 1'b0);
    out_ready = 1'b0;
    beat(3'b000, 64'h77, 4'd8, 1'b0);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_tag", 64'(out_tag), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    beat(3'b010, 64'd6, 4'd2, 1'b1);
    chk("post_rst_data", out_data, 64'd6);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_acc_stage.md
Name: alu_acc_stage

Overview:
- Downstream stage of the ALU. Consumes the 64-bit ALU result and its 3-bit op code.
- add and mul results pass straight through.
- mad results are summed into a 64-bit signed accumulator, and the chain total is emitted on the last beat. This completes the multiply-accumulate operation, which the ALU itself performs only as a multiply.
- Results leave through a 2-entry output FIFO with a valid/ready handshake toward writeback.

Parameters:
OUT_W, 64, data/accumulator width (matches ALU output)
OP_W, 3, op-code width
TAG_W, 4, destination tag carried with each result
OP_ADD, 3'b000, add op code
OP_MUL, 3'b001, mul op code
OP_MAD, 3'b010, multiply-accumulate op code

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat
in_op  input  OP_W  op code of the beat
in_data  input  OUT_W  ALU result, treated as signed
in_tag  input  TAG_W  destination tag
in_last  input  1  final beat of a mad chain (ignored for non-mad)
acc_clr  input  1  synchronous accumulator/chain abort
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream accepts head
out_data  output  OUT_W  result at FIFO head
out_tag  output  TAG_W  tag at FIFO head
out_ovf  output  1  sticky signed overflow of the chain that produced the head (0 for add/mul)
busy  output  1  mad chain in progress (state ACCUM)
drop_cnt  output  8  count of beats with illegal op codes, saturating at 255

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO empty; out_valid=0; out_data/out_tag/out_ovf=0.
  - acc=0; ovf_sticky=0; state=IDLE; busy=0; drop_cnt=0; in_ready=1 after release.
- Accept: a beat is taken on a rising edge with in_valid & in_ready.
- in_ready = (fifo_count < 2). It does not depend combinationally on out_ready.
- Pop: a FIFO entry is removed on a rising edge with out_valid & out_ready.
- Push and pop in the same cycle leave count unchanged.
- Order is strictly in accept order.
- Latency: an output-producing beat accepted at edge N gives out_valid=1 with its data after edge N (next cycle), when the FIFO was empty.
- add/mul, in any state:
  - Push {in_data, in_tag, ovf=0}.
  - Accumulator and state are untouched, so add/mul may interleave inside a mad chain.
- mad: sum = acc + in_data, computed at OUT_W bits with two's-complement wrap.
  - ovf_now = (acc[MSB]==in_data[MSB]) & (sum[MSB]!=acc[MSB]).
  - in_last=0: acc<=sum; ovf_sticky<=ovf_sticky|ovf_now; state<=ACCUM; no push.
  - in_last=1: push {sum, in_tag, ovf_sticky|ovf_now}; then acc<=0, ovf_sticky<=0, state<=IDLE.
  - A single-beat chain (IDLE with in_last=1) emits in_data unchanged and stays IDLE.
- Illegal op code (any other value):
  - Beat is consumed with in_ready honoured; no push.
  - Accumulator and state are unchanged.
  - drop_cnt increments, holding at 255.
- State machine:
  - IDLE -> ACCUM on an accepted mad with in_last=0.
  - ACCUM -> IDLE on an accepted mad with in_last=1, or on acc_clr.
  - No other transitions.
- acc_clr:
  - Sets acc=0, ovf_sticky=0, state=IDLE; FIFO contents are unaffected.
  - If a mad beat is accepted in the same cycle, the clear applies first. The beat then operates on acc=0: its value becomes the new acc, or is emitted if in_last=1.
- Full FIFO: in_ready=0 and the upstream beat holds. The accumulator never advances on an unaccepted beat.
- Reset mid-chain discards the partial sum and all FIFO entries.
- The outputs out_data, out_tag and out_ovf are stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset then add beat (data=64'h5, tag=3) -> out_valid next cycle, out_data=5, tag=3, ovf=0; busy stays 0.
- mad chain 10, -3, 7 (last on third, tag=9) -> single output 14, tag=9, ovf=0; busy=1 between beats, 0 after; no output for the first two beats.
- mad chain 64'h7FFF_FFFF_FFFF_FFFF then 1 (last) -> out_data=64'h8000_0000_0000_0000, out_ovf=1. The next chain 2, 2(last) -> 4 with ovf=0 (sticky cleared).
- out_ready=0 with three add beats offered -> two accepted, in_ready=0 on the third. Release out_ready -> outputs come out in order, then the third is accepted; no loss or duplication.
- mad 100 (last=0), then acc_clr together with mad 5 (last=1) -> output 5. Also: mad 50 then mul 8 then mad 1(last) -> outputs 8 then 51.
- Illegal op 3'b111 repeated 300 times -> no outputs, drop_cnt=255. Assert rst_n=0 mid-chain -> all outputs 0 immediately, busy=0.
